// File: rtl/rv_mc_ctrl.sv
// Multi-cycle control FSM for the RISC-V core: fetch/decode/execute/memory/writeback sequencing.
// Optional macro RV_PERF_CNT_EN adds cycle and retired-instruction counters.
module rv_mc_ctrl #(
   parameter int unsigned WAIT_LIMIT = 255,
   parameter int unsigned CNT_W      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ir,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_is_fetch,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic [2:0]  imm_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        trap,
   output logic [2:0]  state_o
`ifdef RV_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // Counter only has to reach WAIT_LIMIT-1; the timeout fires on the next waiting cycle.
   localparam int unsigned WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   state_t         r_state;
   state_t         w_next;
   logic [WCW-1:0] r_wait;
   logic           r_trap;

   logic [6:0] w_op;
   logic       w_legal;
   logic       w_is_ld;
   logic       w_is_st;
   logic       w_is_br;
   logic       w_is_jal;
   logic       w_is_jalr;
   logic       w_is_auipc;
   logic       w_b_imm;
   logic [2:0] w_imm;
   logic       w_timeout;

   always_comb begin
      w_op       = ir[6:0];
      w_legal    = 1'b1;
      w_imm      = 3'd0;
      w_b_imm    = 1'b0;
      unique case (w_op)
         OP_R:     ;
         OP_IALU:  begin w_imm = 3'd1; w_b_imm = 1'b1; end
         OP_LOAD:  begin w_imm = 3'd1; w_b_imm = 1'b1; end
         OP_STORE: begin w_imm = 3'd2; w_b_imm = 1'b1; end
         OP_BR:    w_imm = 3'd3;
         OP_JAL:   w_imm = 3'd5;
         OP_JALR:  begin w_imm = 3'd1; w_b_imm = 1'b1; end
         OP_LUI:   begin w_imm = 3'd4; w_b_imm = 1'b1; end
         OP_AUIPC: begin w_imm = 3'd4; w_b_imm = 1'b1; end
         default:  w_legal = 1'b0;
      endcase
      w_is_ld    = (w_op == OP_LOAD);
      w_is_st    = (w_op == OP_STORE);
      w_is_br    = (w_op == OP_BR);
      w_is_jal   = (w_op == OP_JAL);
      w_is_jalr  = (w_op == OP_JALR);
      w_is_auipc = (w_op == OP_AUIPC);
      w_timeout  = (WAIT_LIMIT != 0) && !mem_ready &&
                   (r_wait == WCW'(WAIT_LIMIT - 1));
   end

   always_comb begin
      w_next       = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_is_fetch = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      imm_sel      = 3'd0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = 2'd0;
      trap         = 1'b0;
      state_o      = 3'd0;
      if (!rst) begin
         state_o = r_state;
         trap    = r_trap;
         // Operand selects stay valid through MEM/WB because the ALU result is not latched.
         if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            imm_sel   = w_imm;
            alu_a_sel = w_is_auipc;
            alu_b_sel = w_b_imm;
         end
         case (r_state)
            S_FETCH: begin
               mem_req      = 1'b1;
               mem_is_fetch = 1'b1;
               if (mem_ready) begin
                  ir_we  = 1'b1;
                  w_next = S_DECODE;
               end else if (w_timeout) begin
                  w_next = S_TRAP;
               end
            end
            S_DECODE: begin
               imm_sel = w_imm;
               w_next  = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
               if (w_is_br) begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken ? 2'd1 : 2'd0;
                  w_next = S_FETCH;
               end else if (w_is_ld || w_is_st) begin
                  w_next = S_MEM;
               end else begin
                  w_next = S_WB;
               end
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = w_is_st;
               if (mem_ready) begin
                  if (w_is_st) begin
                     pc_we  = 1'b1;
                     w_next = S_FETCH;
                  end else begin
                     w_next = S_WB;
                  end
               end else if (w_timeout) begin
                  w_next = S_TRAP;
               end
            end
            S_WB: begin
               rf_we  = 1'b1;
               pc_we  = 1'b1;
               wb_sel = w_is_ld ? 2'd1 : ((w_is_jal || w_is_jalr) ? 2'd2 : 2'd0);
               pc_sel = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
               w_next = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_wait  <= '0;
         r_trap  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wait <= '0;
         else if (mem_req && !mem_ready)
            r_wait <= r_wait + WCW'(1);
         if (w_next == S_TRAP)
            r_trap <= 1'b1;
      end
   end

`ifdef RV_PERF_CNT_EN
   // pc_we is asserted exactly at the three retirement points (branch EXEC, store MEM, WB).
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (r_state != S_TRAP)
            cyc_cnt <= cyc_cnt + CNT_W'(1);
         if (pc_we)
            ret_cnt <= ret_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
Multi-cycle control FSM for the RISC-V core. It sequences fetch, decode, execute, memory and writeback over the shared datapath: PC, IR, register file, ALU, immediate generator and a single memory port. It decodes the IR opcode to drive immediate-type select, ALU operand muxes, write enables and memory handshakes. Unsupported opcodes and memory timeouts enter a sticky trap state.

Parameters:
WAIT_LIMIT, 255, maximum cycles any memory request may wait for ready before a trap (0 disables the timeout)
CNT_W, 32, width of the performance counters (used only with RV_PERF_CNT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ir  in  32  current instruction register contents
br_taken  in  1  ALU branch-condition result, valid in EXEC
mem_ready  in  1  memory port completes the current request this cycle
mem_req  out  1  memory request strobe
mem_we  out  1  1 = store, 0 = read (fetch or load)
mem_is_fetch  out  1  1 = request is an instruction fetch (address comes from the PC)
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result with bit 0 cleared (JALR)
imm_sel  out  3  0 = none, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = imm
rf_we  out  1  register file write enable
wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4
trap  out  1  sticky fault flag
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset: state = FETCH, wait counter = 0, trap = 0. All outputs 0 in the reset cycle. The first mem_req is asserted in the cycle after rst deasserts.
- All outputs are combinational from the state and IR opcode (ir[6:0]). The only registered elements are the state, the wait counter and the trap flag.
- FETCH:
  - mem_req = 1, mem_is_fetch = 1, mem_we = 0, held until mem_ready.
  - On mem_ready: ir_we = 1, go to DECODE.
- DECODE:
  - Check the opcode. Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Illegal opcode: go to TRAP. Legal: go to EXEC.
  - imm_sel is driven from the opcode in this state (I for 0010011, 0000011 and 1100111; S; B; U; J).
- EXEC: imm_sel is held. Actions by opcode:
  - R-type: alu_b_sel = 0.
  - I-type ALU, load, store: alu_b_sel = 1.
  - AUIPC: alu_a_sel = 1, alu_b_sel = 1.
  - Branch: if br_taken, pc_we = 1 with pc_sel = 1; otherwise pc_we = 1 with pc_sel = 0. Go to FETCH.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_req = 1, mem_we = 1 for stores; held until mem_ready.
  - Load: go to WB.
  - Store: pc_we = 1, pc_sel = 0, go to FETCH.
- WB:
  - rf_we = 1 and pc_we = 1.
  - wb_sel: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - LUI: ALU passes imm (alu_b_sel = 1).
  - Go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH or MEM. Increments each cycle mem_req = 1 and mem_ready = 0.
  - If WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT with mem_ready still 0: go to TRAP next cycle. mem_ready arriving in the same cycle takes priority and completes normally.
- TRAP: all strobes 0, trap = 1. Stays in TRAP until rst.
- Reset mid-request: mem_req drops in the reset cycle. No PC/IR/RF write occurs in that cycle.
- Clock edges per instruction, counted from entry to FETCH with 0-wait memory:
  - branch: 3
  - ALU/JAL/LUI/AUIPC: 4
  - store: 4
  - load: 5

Optional Feature:
RV_PERF_CNT_EN:
- When defined, adds outputs cyc_cnt [CNT_W-1:0] and ret_cnt [CNT_W-1:0].
- cyc_cnt increments every non-reset cycle outside TRAP.
- ret_cnt increments on each instruction completion: the WB exit, the store MEM exit, or the branch EXEC exit.
- Both counters reset to 0 and wrap modulo 2^CNT_W.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), mem_ready immediate -> states 0,1,2,4,0; imm_sel = 1 in DECODE/EXEC; rf_we = 1, wb_sel = 0, pc_sel = 0 in WB; 4 edges.
2. LW (0x0000A103), mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, then WB with wb_sel = 1; no trap.
3. BEQ (0x00208463): br_taken = 1 -> pc_we = 1, pc_sel = 1, imm_sel = 3 in EXEC, back to FETCH; br_taken = 0 -> pc_sel = 0.
4. JALR (0x000080E7) -> WB with wb_sel = 2, pc_sel = 2, rf_we = 1; JAL (0x008000EF) -> imm_sel = 5, pc_sel = 1.
5. Illegal IR 0x0000007F -> TRAP after DECODE; trap = 1 and all strobes 0 for 10+ cycles; rst returns to FETCH with trap = 0.
6. WAIT_LIMIT = 4, mem_ready held 0 in FETCH -> TRAP entered after 4 waiting cycles; repeat with mem_ready rising on the 4th waiting cycle -> normal DECODE, no trap.
